// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops until both operands arrive
// (direct, same-cycle CDB bypass, or CDB wakeup), then issues through a registered slot.

module alu_rs_entry #(
   parameter int TAG_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr,
   input  logic              clr,
   input  logic              d_is_arith,
   input  logic [2:0]        d_funct3,
   input  logic              d_funct7,
   input  logic              d_src1_valid,
   input  logic [31:0]       d_src1_data,
   input  logic [TAG_W-1:0]  d_src1_tag,
   input  logic              d_src2_valid,
   input  logic [31:0]       d_src2_data,
   input  logic [TAG_W-1:0]  d_src2_tag,
   input  logic [TAG_W-1:0]  d_dest_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [31:0]       cdb_data,
   output logic              busy,
   output logic              ready,
   output logic              is_arith,
   output logic [2:0]        funct3,
   output logic              funct7,
   output logic [31:0]       src1_data,
   output logic [31:0]       src2_data,
   output logic [TAG_W-1:0]  dest_tag
);
   logic             src1_valid, src2_valid;
   logic [TAG_W-1:0] src1_tag, src2_tag;
   logic             byp1, byp2, hit1, hit2;

   assign byp1  = cdb_valid && (cdb_tag == d_src1_tag);
   assign byp2  = cdb_valid && (cdb_tag == d_src2_tag);
   assign hit1  = cdb_valid && busy && !src1_valid && (cdb_tag == src1_tag);
   assign hit2  = cdb_valid && busy && !src2_valid && (cdb_tag == src2_tag);
   assign ready = busy && src1_valid && src2_valid;

   // wr only targets a free entry and clr only a ready one, so they never collide
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy <= 1'b0;
      end else if (wr) begin
         busy       <= 1'b1;
         is_arith   <= d_is_arith;
         funct3     <= d_funct3;
         funct7     <= d_funct7;
         dest_tag   <= d_dest_tag;
         src1_valid <= d_src1_valid || byp1;
         src1_data  <= d_src1_valid ? d_src1_data : cdb_data;
         src1_tag   <= d_src1_tag;
         src2_valid <= d_src2_valid || byp2;
         src2_data  <= d_src2_valid ? d_src2_data : cdb_data;
         src2_tag   <= d_src2_tag;
      end else begin
         if (clr) busy <= 1'b0;
         if (hit1) begin
            src1_valid <= 1'b1;
            src1_data  <= cdb_data;
         end
         if (hit2) begin
            src2_valid <= 1'b1;
            src2_data  <= cdb_data;
         end
      end
   end
endmodule

module alu_rs #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic                     disp_is_arith,
   input  logic [2:0]               disp_funct3,
   input  logic                     disp_funct7,
   input  logic                     disp_src1_valid,
   input  logic                     disp_src2_valid,
   input  logic [31:0]              disp_src1_data,
   input  logic [31:0]              disp_src2_data,
   input  logic [TAG_W-1:0]         disp_src1_tag,
   input  logic [TAG_W-1:0]         disp_src2_tag,
   input  logic [TAG_W-1:0]         disp_dest_tag,
   input  logic                     cdb_valid,
   input  logic [TAG_W-1:0]         cdb_tag,
   input  logic [31:0]              cdb_data,
   output logic                     iss_valid,
   input  logic                     iss_ready,
   output logic                     iss_is_arith,
   output logic [2:0]               iss_funct3,
   output logic                     iss_funct7,
   output logic [31:0]              iss_src1_data,
   output logic [31:0]              iss_src2_data,
   output logic [TAG_W-1:0]         iss_dest_tag,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0]             e_busy, e_ready, e_arith, e_f7, alloc_oh, sel_oh;
   logic [DEPTH-1:0][2:0]        e_f3;
   logic [DEPTH-1:0][31:0]       e_s1, e_s2;
   logic [DEPTH-1:0][TAG_W-1:0]  e_dest;
   logic [IW-1:0]                sel_idx;
   logic                         alloc_found, any_ready, disp_fire, slot_load;

   // lowest free entry for dispatch, lowest ready entry for the slot
   always_comb begin
      alloc_oh    = '0;
      alloc_found = 1'b0;
      sel_oh      = '0;
      sel_idx     = '0;
      any_ready   = 1'b0;
      count       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count = count + CW'(e_busy[i]);
         if (!e_busy[i] && !alloc_found) begin
            alloc_oh[i] = 1'b1;
            alloc_found = 1'b1;
         end
         if (e_ready[i] && !any_ready) begin
            sel_oh[i] = 1'b1;
            sel_idx   = IW'(i);
            any_ready = 1'b1;
         end
      end
   end

   assign disp_ready = (count < CW'(DEPTH));
   assign disp_fire  = disp_valid && disp_ready && !flush;
   assign slot_load  = (!iss_valid || iss_ready) && any_ready && !flush;

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      alu_rs_entry #(.TAG_W(TAG_W)) u_ent (
         .clk(clk), .rst(rst), .flush(flush),
         .wr(disp_fire && alloc_oh[g]), .clr(slot_load && sel_oh[g]),
         .d_is_arith(disp_is_arith), .d_funct3(disp_funct3), .d_funct7(disp_funct7),
         .d_src1_valid(disp_src1_valid), .d_src1_data(disp_src1_data), .d_src1_tag(disp_src1_tag),
         .d_src2_valid(disp_src2_valid), .d_src2_data(disp_src2_data), .d_src2_tag(disp_src2_tag),
         .d_dest_tag(disp_dest_tag),
         .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
         .busy(e_busy[g]), .ready(e_ready[g]), .is_arith(e_arith[g]), .funct3(e_f3[g]),
         .funct7(e_f7[g]), .src1_data(e_s1[g]), .src2_data(e_s2[g]), .dest_tag(e_dest[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         iss_valid <= 1'b0;
      end else if (slot_load) begin
         iss_valid     <= 1'b1;
         iss_is_arith  <= e_arith[sel_idx];
         iss_funct3    <= e_f3[sel_idx];
         iss_funct7    <= e_f7[sel_idx];
         iss_src1_data <= e_s1[sel_idx];
         iss_src2_data <= e_s2[sel_idx];
         iss_dest_tag  <= e_dest[sel_idx];
      end else if (iss_ready) begin
         iss_valid <= 1'b0;
      end
   end
endmodule
